pdp10_find_shift: RTL and testbench

//  Inverse companion of the 36-bit barrel shifter: takes a word and computes the left-shift

---
 rtl/pdp10_find_shift.sv | 113 +++++++++++
 tb/tb_pdp10_find_shift.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdp10_find_shift.sv
// Iterative find-first / normalize companion to the 36-bit barrel shifter (JFFO and NORM).
// Define KV10_NORM_EN to enable the NORM (redundant-sign) mode; otherwise mode is ignored.
module pdp10_find_shift #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        mode,
  input  logic [35:0] inword,
  output logic        ready,
  output logic        done,
  output logic        zero,
  output logic [8:0]  count,
  output logic [35:0] outword
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [5:0] STEPCNT = 6'(STEP);
  localparam logic [5:0] LASTCNT = 6'(36 - STEP);

  state_t      state;
  logic [35:0] work;
  logic [35:0] scan;
  logic [35:0] scanLoad;
  logic [5:0]  cnt;
  logic        isZero;

  logic [STEP-1:0] chunk;
  logic            hit;
  logic [5:0]      off;

`ifdef KV10_NORM_EN
  // NORM looks for the first bit differing from the sign; pre-xoring the field with
  // the sign (virtual bit 36 becomes a constant 1) turns it into a plain first-one scan.
  assign scanLoad = mode ? {inword[34:0] ^ {35{inword[35]}}, 1'b1} : inword;
`else
  logic unusedMode;
  assign unusedMode = mode;
  assign scanLoad   = inword;
`endif

  always_comb begin
    chunk = scan[35 -: STEP];
    hit   = 1'b0;
    off   = '0;
    for (int i = 0; i < STEP; i++) begin
      if (!hit && chunk[STEP-1-i]) begin
        hit = 1'b1;
        off = 6'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      zero    <= 1'b0;
      count   <= '0;
      outword <= '0;
      work    <= '0;
      scan    <= '0;
      cnt     <= '0;
      isZero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work   <= inword;
            scan   <= scanLoad;
            cnt    <= '0;
            isZero <= (inword == 36'd0);
            ready  <= 1'b0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          // A zero operand ends on the last chunk whether or not a bit was found.
          if (hit || cnt == LASTCNT) begin
            state <= DONE;
            done  <= 1'b1;
            if (isZero) begin
              zero    <= 1'b1;
              count   <= '0;
              outword <= '0;
            end else begin
              zero    <= 1'b0;
              count   <= 9'(cnt + off);
              outword <= work << off;
            end
          end else begin
            work <= work << STEP;
            scan <= scan << STEP;
            cnt  <= cnt + STEPCNT;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdp10_find_shift.sv
// Bench for pdp10_find_shift: vector table, random vectors against a direct model,
// plus reset-abort, held-start and back-to-back sequences, all through a scoreboard.
module tb_pdp10_find_shift;

  localparam int STEP = 4;
  localparam int NCHUNK = 36 / STEP;
`ifdef KV10_NORM_EN
  localparam bit NORMEN = 1'b1;
`else
  localparam bit NORMEN = 1'b0;
`endif

  typedef struct {
    logic        mode;
    logic [35:0] word;
    logic [8:0]  count;
    logic [35:0] out;
    logic        zero;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [35:0] inword = '0;
  logic        ready, done, zero;
  logic [8:0]  count;
  logic [35:0] outword;

  int   nCompared = 0;
  int   nMismatch = 0;
  int   cycle = 0;
  int   accCount = 0;
  int   doneCount = 0;
  int   lastAcc = 0;
  int   lastDone = 0;
  exp_t pend;
  exp_t sb[$];
  exp_t table_[12];

  pdp10_find_shift #(.STEP(STEP)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .inword(inword),
    .ready(ready), .done(done), .zero(zero), .count(count), .outword(outword)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic exp_t mk(logic m, logic [35:0] w, logic [8:0] c, logic [35:0] o,
                              logic z, int l);
    exp_t e;
    e.mode = m; e.word = w; e.count = c; e.out = o; e.zero = z; e.lat = l; e.acc = 0;
    return e;
  endfunction

  // Direct reference: locate the significant bit by a plain scan, no chunking.
  function automatic exp_t model(logic m, logic [35:0] w);
    int  idx;
    bit  found;
    idx = 35;
    found = 1'b0;
    if (w == 36'd0) return mk(m, w, 9'd0, 36'd0, 1'b1, NCHUNK);
    if (m && NORMEN) begin
      for (int i = 1; i <= 35; i++)
        if (!found && w[35-i] != w[35]) begin found = 1'b1; idx = i - 1; end
    end else begin
      for (int i = 0; i <= 35; i++)
        if (!found && w[35-i]) begin found = 1'b1; idx = i; end
    end
    return mk(m, w, 9'(idx), w << idx, 1'b0, idx / STEP + 1);
  endfunction

  task automatic checkOutput(string name, logic [35:0] act, logic [35:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0o expected %0o (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Scoreboard: push on each accepted start, pop and compare on each done pulse.
  always @(negedge clk) begin
    exp_t r;
    if (start && ready && reset_n) begin
      r = pend;
      r.acc = cycle + 1;
      sb.push_back(r);
      accCount++;
      lastAcc = cycle + 1;
    end
    if (done) begin
      doneCount++;
      lastDone = cycle;
      if (sb.size() == 0) begin
        checkOutput("spurious_done", 36'd1, 36'd0);
      end else begin
        r = sb.pop_front();
        checkOutput($sformatf("count[%0o m%0d]", r.word, r.mode), 36'(count), 36'(r.count));
        checkOutput($sformatf("outword[%0o m%0d]", r.word, r.mode), outword, r.out);
        checkOutput($sformatf("zero[%0o m%0d]", r.word, r.mode), 36'(zero), 36'(r.zero));
        checkOutput($sformatf("latency[%0o m%0d]", r.word, r.mode), 36'(cycle - r.acc),
                    36'(r.lat));
      end
    end
  end

  task automatic applyStimulus(logic m, logic [35:0] w, exp_t e);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk); #1;
      if (ready) ok = 1'b1;
    end
    if (!ok) begin
      checkOutput("ready_timeout", 36'd0, 36'd1);
    end else begin
      mode = m; inword = w; pend = e; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && ready) ok = 1'b1;
    end
    if (!ok) begin
      checkOutput("done_timeout", 36'd0, 36'd1);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accBefore, doneBefore;
    logic [63:0] r64;
    logic [35:0] w;
    logic m;

    table_[0] = mk(0, 36'o000000000001, 9'd35, 36'o400000000000, 0, 9);
    table_[1] = mk(0, 36'o000001000000, 9'd17, 36'o400000000000, 0, 5);
    table_[2] = mk(0, 36'o000000000000, 9'd0, 36'o000000000000, 1, 9);
    table_[3] = mk(1, 36'o000000000000, 9'd0, 36'o000000000000, 1, 9);
    table_[4] = mk(0, 36'o400000000000, 9'd0, 36'o400000000000, 0, 1);
    table_[5] = mk(0, 36'o000000000010, 9'd32, 36'o400000000000, 0, 9);
    table_[6] = mk(0, 36'o040000000000, 9'd3, 36'o400000000000, 0, 1);
    table_[7] = mk(1, 36'o400000000000, 9'd0, 36'o400000000000, 0, 1);
`ifdef KV10_NORM_EN
    table_[8]  = mk(1, 36'o000001000000, 9'd16, 36'o200000000000, 0, 5);
    table_[9]  = mk(1, 36'o777777777777, 9'd35, 36'o400000000000, 0, 9);
    table_[10] = mk(1, 36'o700000000000, 9'd2, 36'o400000000000, 0, 1);
    table_[11] = mk(1, 36'o100000000000, 9'd1, 36'o200000000000, 0, 1);
`else
    table_[8]  = mk(1, 36'o000001000000, 9'd17, 36'o400000000000, 0, 5);
    table_[9]  = mk(1, 36'o777777777777, 9'd0, 36'o777777777777, 0, 1);
    table_[10] = mk(1, 36'o700000000000, 9'd0, 36'o700000000000, 0, 1);
    table_[11] = mk(1, 36'o100000000000, 9'd2, 36'o400000000000, 0, 1);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 36'(ready), 36'd1);
    checkOutput("rst_done", 36'(done), 36'd0);
    checkOutput("rst_zero", 36'(zero), 36'd0);
    checkOutput("rst_count", 36'(count), 36'd0);
    checkOutput("rst_outword", outword, 36'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(table_[i].mode, table_[i].word, table_[i]);
      waitIdle();
    end

    for (int i = 0; i < 24; i++) begin
      r64 = {$urandom, $urandom};
      w = r64[35:0] >> $urandom_range(35, 0);
      if ($urandom_range(1, 0) == 1) w = ~w;
      m = 1'($urandom_range(1, 0));
      applyStimulus(m, w, model(m, w));
      waitIdle();
    end

    // Back-to-back: second start lands in the clock ready returns high.
    applyStimulus(0, 36'o400000000000, model(0, 36'o400000000000));
    applyStimulus(0, 36'o000000000001, model(0, 36'o000000000001));
    checkOutput("b2b_accept_gap", 36'(lastAcc - lastDone), 36'd2);
    waitIdle();

    // Held start: every accepted start must yield exactly one done.
    accBefore = accCount;
    doneBefore = doneCount;
    pend = model(0, 36'o000001000000);
    mode = 1'b0; inword = 36'o000001000000; start = 1'b1;
    repeat (40) @(posedge clk);
    #1 start = 1'b0;
    waitIdle();
    checkOutput("held_done_per_start", 36'(doneCount - doneBefore), 36'(accCount - accBefore));
    checkOutput("held_multiple_accepts", 36'(accCount - accBefore > 1), 36'd1);

    // Reset during SCAN clock 3 aborts without a done pulse.
    doneBefore = doneCount;
    applyStimulus(0, 36'o000000000001, model(0, 36'o000000000001));
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    checkOutput("abort_ready", 36'(ready), 36'd1);
    checkOutput("abort_done", 36'(done), 36'd0);
    checkOutput("abort_zero", 36'(zero), 36'd0);
    checkOutput("abort_count", 36'(count), 36'd0);
    checkOutput("abort_outword", outword, 36'd0);
    reset_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 36'(doneCount - doneBefore), 36'd0);

    applyStimulus(1, 36'o777777777777, model(1, 36'o777777777777));
    waitIdle();
    checkOutput("scoreboard_empty", 36'(sb.size()), 36'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
